// File: rtl/pkt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_pkg
//  Description : Shared definitions for the packet extractor: header field
//                bit positions, the extractor FSM state type and small
//                helper functions (saturating counter increment, header
//                parity check).
//  Revision    : 1.0 - initial release
// ============================================================================
package pkt_pkg;

    // Header word layout: [31:24] type, [23:16] dest, [15:8] reserved
    // (bit 15 doubles as the parity bit when parity checking is built in),
    // [7:0] payload length in words.
    localparam int c_type_msb   = 31;
    localparam int c_type_lsb   = 24;
    localparam int c_dest_msb   = 23;
    localparam int c_dest_lsb   = 16;
    localparam int c_parity_bit = 15;
    localparam int c_len_msb    = 7;
    localparam int c_len_lsb    = 0;
    localparam int c_len_w      = c_len_msb - c_len_lsb + 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HDR      = 3'd1,
        EMIT_HDR = 3'd2,
        PAY      = 3'd3,
        EMIT_PAY = 3'd4,
        DROP     = 3'd5
    } extract_state_t;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    // Bit 15 must make the XOR over {[31:16], [15], [7:0]} even.
    function automatic logic hdr_parity_ok(input logic [31:0] hdr);
        return (^{hdr[c_type_msb:c_dest_lsb], hdr[c_parity_bit],
                  hdr[c_len_msb:c_len_lsb]}) == 1'b0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/packet_extractor_if.sv
`default_nettype none
// ============================================================================
//  Module      : packet_extractor_if
//  Description : Bundles the buffer read handshake and the output packet
//                stream of the packet extractor.
//                  buffer_empty, rd_ack, rd_data : from the buffer
//                  rd_req                        : to the buffer
//                  out_valid/out_data/out_sop/out_eop : stream beat
//                  out_ready                     : stream backpressure
//                modport master : the extractor side
//                modport slave  : the buffer + stream sink side
//  Revision    : 1.0 - initial release
// ============================================================================
interface packet_extractor_if;

    logic        buffer_empty;
    logic        rd_req;
    logic        rd_ack;
    logic [31:0] rd_data;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sop;
    logic        out_eop;

    modport master (
        input  buffer_empty,
        output rd_req,
        input  rd_ack,
        input  rd_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_sop,
        output out_eop
    );

    modport slave (
        output buffer_empty,
        input  rd_req,
        output rd_ack,
        output rd_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_sop,
        input  out_eop
    );

endinterface
`default_nettype wire

// File: rtl/pkt_beat_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_beat_reg
//  Description : Single-entry output register slice for the packet stream.
//                Holds one beat (data/sop/eop) with valid/ready.
//                  clk, rst_n   : clock, synchronous active-low reset
//                  enable       : when low the slice neither loads nor
//                                 accepts, so its outputs hold
//                  load, load_* : write a new beat (only issued when empty)
//                  out_*        : registered stream beat
//                  accept       : beat transferred at this clock edge
//  Revision    : 1.0 - initial release
// ============================================================================
module pkt_beat_reg #(
    parameter int DATA_W = 32
) (
    input  wire               clk,
    input  wire               rst_n,
    input  wire               enable,
    input  wire               load,
    input  wire  [DATA_W-1:0] load_data,
    input  wire               load_sop,
    input  wire               load_eop,
    input  wire               out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic              accept
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_sop;
    logic              r_eop;

    assign accept = enable & r_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
        end else if (enable) begin
            if (load) begin
                r_valid <= 1'b1;
                r_data  <= load_data;
                r_sop   <= load_sop;
                r_eop   <= load_eop;
            end else if (accept) begin
                // Data/sop/eop keep their last value; only valid drops.
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_sop   = r_sop;
    assign out_eop   = r_eop;

endmodule
`default_nettype wire

// File: rtl/packet_extractor.sv
`default_nettype none
// ============================================================================
//  Module      : packet_extractor
//  Description : Drains 32-bit words from a buffer over an rd_req/rd_ack
//                handshake (one read outstanding at most) and reassembles
//                them into packets (header + LEN payload words) emitted on
//                a valid/ready stream with sop/eop. Headers with LEN above
//                MAX_PKT_WORDS are consumed and dropped.
//                  clk, rst_n  : clock, synchronous active-low reset
//                  enable      : low freezes FSM, counters and rd_req
//                  bus         : buffer handshake + output stream (master)
//                  pkt_count   : packets fully emitted (saturating)
//                  drop_count  : packets dropped (saturating)
//                  busy        : FSM not in IDLE
//                Build option PKT_EXTRACT_PARITY_EN: header bit 15 carries
//                even parity over bits [31:16] and [7:0]; a mismatch drops
//                the packet. Without it, header bits [15:8] are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module packet_extractor
    import pkt_pkg::*;
#(
    parameter int EXTRACTOR_ID  = 0,
    parameter int MAX_PKT_WORDS = 32
) (
    input  wire                clk,
    input  wire                rst_n,
    input  wire                enable,
    packet_extractor_if.master bus,
    output logic [15:0]        pkt_count,
    output logic [15:0]        drop_count,
    output logic               busy
);

    localparam logic [c_len_w-1:0] c_max_len = c_len_w'(MAX_PKT_WORDS);

    extract_state_t     r_state;
    logic               r_req_q;        // read request issued, ack pending
    logic [c_len_w-1:0] r_len;
    logic [c_len_w-1:0] r_cnt;          // payload / drop words remaining
    logic [15:0]        r_pkt_count;
    logic [15:0]        r_drop_count;
    logic               r_held_valid;   // word acked while enable was low
    logic [31:0]        r_held_data;

    logic               w_ack_live;
    logic               w_word_valid;
    logic [31:0]        w_word;
    logic [c_len_w-1:0] w_len;
    logic               w_hdr_bad;
    logic               w_accept;
    logic               w_beat_free;
    logic               w_want;
    logic               w_req_set;
    logic               w_load;
    logic               w_load_sop;
    logic               w_load_eop;

    // An ack with nothing outstanding is stray and ignored.
    assign w_ack_live   = bus.rd_ack & r_req_q;
    // A word parked during enable-low is consumed first once enable returns.
    assign w_word_valid = enable & (w_ack_live | r_held_valid);
    assign w_word       = r_held_valid ? r_held_data : bus.rd_data;
    assign w_len        = w_word[c_len_msb:c_len_lsb];

`ifdef PKT_EXTRACT_PARITY_EN
    assign w_hdr_bad = (w_len > c_max_len) | ~hdr_parity_ok(w_word);
`else
    assign w_hdr_bad = (w_len > c_max_len);
`endif

    assign w_beat_free = ~bus.out_valid | w_accept;

    // Does the FSM want the next word? The EMIT states only want it in the
    // cycle their beat is accepted, which lets the read overlap that beat.
    always_comb begin
        w_want = 1'b0;
        case (r_state)
            IDLE, HDR, PAY: w_want = 1'b1;
            EMIT_HDR:       w_want = w_accept & (r_len != '0);
            EMIT_PAY:       w_want = w_accept & (r_cnt != '0);
            DROP:           w_want = (r_cnt != '0);
            default:        w_want = 1'b0;
        endcase
    end

    assign w_req_set = enable & ~r_req_q & ~r_held_valid & w_beat_free & w_want;

    // Drop the request in the ack cycle so the buffer cannot read twice.
    assign bus.rd_req = r_req_q & ~bus.rd_ack;

    assign w_load     = w_word_valid & (((r_state == HDR) & ~w_hdr_bad) | (r_state == PAY));
    assign w_load_sop = (r_state == HDR);
    assign w_load_eop = (r_state == HDR) ? (w_len == '0) : (r_cnt == c_len_w'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_req_q      <= 1'b0;
            r_len        <= '0;
            r_cnt        <= '0;
            r_pkt_count  <= 16'd0;
            r_drop_count <= 16'd0;
            r_held_valid <= 1'b0;
            r_held_data  <= 32'd0;
        end else begin
            // The buffer has already delivered the word, so it is kept even
            // while frozen.
            if (!enable && w_ack_live) begin
                r_held_valid <= 1'b1;
                r_held_data  <= bus.rd_data;
            end else if (enable) begin
                r_held_valid <= 1'b0;
            end

            if (w_ack_live) begin
                r_req_q <= 1'b0;
            end else if (w_req_set) begin
                r_req_q <= 1'b1;
            end

            if (enable) begin
                case (r_state)
                    IDLE: begin
                        r_state <= HDR;
                    end
                    HDR: begin
                        if (w_word_valid) begin
                            r_len <= w_len;
                            if (w_hdr_bad) begin
                                r_cnt   <= w_len;
                                r_state <= DROP;
                            end else begin
                                r_state <= EMIT_HDR;
                            end
                        end
                    end
                    EMIT_HDR: begin
                        if (w_accept) begin
                            if (r_len == '0) begin
                                r_pkt_count <= sat_inc16(r_pkt_count);
                                r_state     <= IDLE;
                            end else begin
                                r_cnt   <= r_len;
                                r_state <= PAY;
                            end
                        end
                    end
                    PAY: begin
                        if (w_word_valid) begin
                            r_cnt   <= r_cnt - c_len_w'(1);
                            r_state <= EMIT_PAY;
                        end
                    end
                    EMIT_PAY: begin
                        if (w_accept) begin
                            if (r_cnt != '0) begin
                                r_state <= PAY;
                            end else begin
                                r_pkt_count <= sat_inc16(r_pkt_count);
                                r_state     <= IDLE;
                            end
                        end
                    end
                    DROP: begin
                        // Zero-length drops only arise from a parity failure.
                        if (r_cnt == '0) begin
                            r_drop_count <= sat_inc16(r_drop_count);
                            r_state      <= IDLE;
                        end else if (w_word_valid) begin
                            r_cnt <= r_cnt - c_len_w'(1);
                            if (r_cnt == c_len_w'(1)) begin
                                r_drop_count <= sat_inc16(r_drop_count);
                                r_state      <= IDLE;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    pkt_beat_reg #(
        .DATA_W (32)
    ) u_beat (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .load      (w_load),
        .load_data (w_word),
        .load_sop  (w_load_sop),
        .load_eop  (w_load_eop),
        .out_ready (bus.out_ready),
        .out_valid (bus.out_valid),
        .out_data  (bus.out_data),
        .out_sop   (bus.out_sop),
        .out_eop   (bus.out_eop),
        .accept    (w_accept)
    );

    assign pkt_count  = r_pkt_count;
    assign drop_count = r_drop_count;
    assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire
